// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM access sequencer: state encoding, address
// map and the default wait-state count, so that the hazard unit and the top
// level agree on the same values.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sram_state_t;

  // Byte address that maps onto SRAM word 0.
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

  // BUSY cycles per access; WAIT_CYCLES x clock period must exceed the 30 ns
  // SRAM read delay.
  localparam int DEFAULT_WAIT_CYCLES = 4;

  // CPU byte address to SRAM word address. The subtraction wraps modulo 2^32
  // and the result is truncated, so out-of-range addresses alias silently.
  function automatic logic [16:0] word_addr(input logic [31:0] address,
                                            input logic [31:0] base);
    return 17'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM
// controller. The pipeline is the master; the controller is the slave.
interface sram_controller_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, wdata,
    input  rdata, ready
  );

  modport slave (
    input  rd_en, wr_en, address, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Sequences single-word MEM-stage accesses onto the 64-bit external SRAM.
// Each access spends WAIT_CYCLES cycles in BUSY and one cycle in DONE; ready
// stays low meanwhile so the pipeline freezes until the access completes.
//
// state | meaning
// IDLE  | no access in flight; a request is latched and BUSY entered
// BUSY  | address (and write data) on the SRAM pins, wait states counting
// DONE  | access complete, ready high for one cycle, then back to IDLE
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_controller_if.slave         bus,
  output logic                     SRAM_WE_N,
  output logic [16:0]              SRAM_ADDR,
  inout  wire  [63:0]              SRAM_DQ
);

  localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  sram_state_t       state;
  logic [CNT_W-1:0]  count;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              dq_oe;

  // SRAM_ADDR doubles as the latched word address: it is loaded on the
  // IDLE->BUSY edge and otherwise keeps its last value. SRAM_WE_N and dq_oe
  // are registered so they are asserted exactly for the BUSY cycles.

  // Tristate data bus: only the upper half stays zero during writes.
  assign SRAM_DQ = dq_oe ? {32'b0, wdata_q} : 'z;

  // A request still asserted in DONE reads back as served.
  assign bus.ready = ~(bus.rd_en | bus.wr_en) | (state == ST_DONE);
  assign bus.rdata = rdata_q;

  // Access sequencer with registered SRAM pin controls and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.rd_en | bus.wr_en) begin
            // write wins when both requests are raised together
            wr_q      <= bus.wr_en;
            wdata_q   <= bus.wdata;
            SRAM_ADDR <= word_addr(bus.address, BASE_ADDR);
            SRAM_WE_N <= ~bus.wr_en;
            dq_oe     <= bus.wr_en;
            count     <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          count <= count + CNT_W'(1);
          if (count == CNT_LAST) begin
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            state     <= ST_DONE;
            if (!wr_q) begin
              // odd words live in the upper half of the 64-bit SRAM word
              rdata_q <= SRAM_ADDR[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: reset behaviour, a directed vector
// table, multi-cycle corner sequences and randomized accesses against a
// word-level reference memory.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [63:0] sram_dq;
  logic        model_oe = 1'b1;

  always #5 clk = ~clk;

  sram_controller_if bus ();

  sram_controller #(.WAIT_CYCLES(WAIT), .BASE_ADDR(32'd1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_WE_N (sram_we_n),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq)
  );

  // External SRAM: 32-bit words, an even/odd pair shares one 64-bit read beat.
  logic [31:0] sram_mem [0:131071];

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] = sram_dq[31:0];
  end

  assign sram_dq = (sram_we_n && model_oe) ?
                   {sram_mem[{sram_addr[16:1], 1'b1}], sram_mem[{sram_addr[16:1], 1'b0}]} :
                   64'bz;

  // Reference: what each CPU word should hold, and what rdata should show.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return ((a - 32'd1024) >> 2) % 32'h20000;
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned i);
    if (ref_mem.exists(i)) return ref_mem[i];
    return 32'h0;
  endfunction

  // One complete access, started right after a negedge; returns at the
  // negedge following DONE with the controller back in IDLE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag,
                            output logic [31:0] got);
    int          low;
    int unsigned i;
    i = widx(addr);
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.address = addr;
    bus.wdata   = wdata;
    #1;
    low = 0;
    while (!bus.ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    check({tag, " ready_low_cycles"}, 64'(low), 64'(WAIT + 1));
    check({tag, " sram_addr"}, 64'(sram_addr), 64'(i));
    check({tag, " we_n_done"}, 64'(sram_we_n), 64'd1);
    if (wr) begin
      ref_mem[i] = wdata;
      check({tag, " sram_word"}, 64'(sram_mem[i]), 64'(wdata));
    end else begin
      ref_rdata = ref_read(i);
    end
    check({tag, " rdata"}, 64'(bus.rdata), 64'(ref_rdata));
    got = bus.rdata;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    int          op;

    for (int k = 0; k < 131072; k++) sram_mem[k] = 32'h0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.address = 32'h0;
    bus.wdata   = 32'h0;

    // reset asserted mid-cycle takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    check("rst we_n", 64'(sram_we_n), 64'd1);
    check("rst dq_oe", 64'(dut.dq_oe), 64'd0);
    check("rst rdata", 64'(bus.rdata), 64'd0);
    check("rst ready", 64'(bus.ready), 64'd1);
    check("rst sram_addr", 64'(sram_addr), 64'd0);
    check("rst state", 64'(dut.state), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'h11111111, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h22222222, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 32'h22222222};
    vecs[5] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'h11111111};
    vecs[6] = '{1'b1, 1'b1, 32'd1032, 32'h00000005, 32'h11111111};
    vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'h00000005};
    for (int v = 0; v < 8; v++) begin
      run_access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, $sformatf("vec%0d", v), got);
      check($sformatf("vec%0d table_rdata", v), 64'(got), 64'(vecs[v].exp_rdata));
    end

    // write request dropped in BUSY cycle 2 still completes on schedule
    bus.wr_en = 1'b1; bus.address = 32'd1036; bus.wdata = 32'h33333333;
    @(negedge clk);                         // cycle 1
    @(negedge clk);                         // cycle 2
    bus.wr_en = 1'b0;
    @(negedge clk);                         // cycle 3
    @(negedge clk);                         // cycle 4
    check("drop we_n_busy4", 64'(sram_we_n), 64'd0);
    @(negedge clk);                         // cycle 5: DONE
    check("drop we_n_done", 64'(sram_we_n), 64'd1);
    bus.rd_en = 1'b1; bus.address = 32'd1024;
    #1;
    check("drop ready_in_done", 64'(bus.ready), 64'd1);
    bus.rd_en = 1'b0;
    @(negedge clk);                         // cycle 6: IDLE
    bus.rd_en = 1'b1;
    #1;
    check("drop ready_in_idle", 64'(bus.ready), 64'd0);
    bus.rd_en = 1'b0;
    @(negedge clk);
    check("drop no_new_access", 64'(sram_we_n), 64'd1);
    check("drop sram_addr_held", 64'(sram_addr), 64'(widx(32'd1036)));
    ref_mem[widx(32'd1036)] = 32'h33333333;
    check("drop sram_word", 64'(sram_mem[widx(32'd1036)]), 64'h33333333);

    // reset in the middle of a write releases the bus at once
    bus.wr_en = 1'b1; bus.address = 32'd1040; bus.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    check("rstw we_n_busy2", 64'(sram_we_n), 64'd0);
    #2 rst = 1'b1; bus.wr_en = 1'b0;
    #1;
    check("rstw we_n", 64'(sram_we_n), 64'd1);
    check("rstw dq_oe", 64'(dut.dq_oe), 64'd0);
    check("rstw rdata", 64'(bus.rdata), 64'd0);
    check("rstw ready", 64'(bus.ready), 64'd1);
    ref_mem[widx(32'd1040)] = 32'hA5A5A5A5;  // landed on the BUSY edges before reset
    ref_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset during a read in BUSY cycle 3, then the same read re-issued
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, "prerd", got);
    bus.rd_en = 1'b1; bus.address = 32'd1024;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);                         // cycle 3
    #2 rst = 1'b1;
    #1;
    check("rstr rdata", 64'(bus.rdata), 64'd0);
    check("rstr we_n", 64'(sram_we_n), 64'd1);
    check("rstr state", 64'(dut.state), 64'(ST_IDLE));
    ref_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, "rerd", got);
    check("rerd value", 64'(got), 64'h11111111);

    // randomized traffic, including addresses below the base that wrap
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0)
        addr = 32'd1024 - 32'(4 * $urandom_range(1, 8));
      else
        addr = 32'd1024 + 32'(4 * $urandom_range(0, 31));
      addr = addr + 32'($urandom_range(0, 3));
      run_access(op != 1, op != 0, addr, $urandom, $sformatf("rnd%0d", n), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
